lvds_rx_frame_aligner: RTL and testbench

Receive-side word aligner for one 9-lane, 6x-deserialized LVDS port: 8 data lanes plus 1 frame-clock lane. It watches the deserialized frame-clock lane, pulses the deserializer's `rx_data_align` (bit-slip) input until the expected frame pattern is stable, then declares lock and forwards the aligned 48-bit data word. It sits between each `lvds_rx_9chan_6x` instance and the capture logic, in the `rx_outclock` domain. It is the receiving counterpart of the framed LVDS transmit pattern.

---
 rtl/lvds_rx_pkg.sv | 34 +++
 rtl/lvds_rx_sat_counter.sv | 30 +++
 rtl/lvds_rx_frame_aligner.sv | 168 ++++++++++++++++
 tb/tb_lvds_rx_frame_aligner.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_rx_pkg.sv
// Shared definitions for the LVDS receive word aligner: lane geometry,
// the default frame-lane pattern and the aligner state encoding.
package lvds_rx_pkg;

  localparam int LVDS_DESER_FACTOR = 6;
  localparam int LVDS_RX_LANES     = 9;

  localparam logic [LVDS_DESER_FACTOR-1:0] LVDS_FRAME_PATTERN_DEFAULT = 6'b111000;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_SLIP   = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_LOCKED = 3'd4;
  localparam logic [2:0] ST_FAIL   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_CHECK  = ST_CHECK,
    S_SLIP   = ST_SLIP,
    S_WAIT   = ST_WAIT,
    S_LOCKED = ST_LOCKED,
    S_FAIL   = ST_FAIL
  } lvds_rx_state_e;

  // Extract one deserialized lane; lane i occupies bits [6i+5:6i].
  function automatic logic [LVDS_DESER_FACTOR-1:0] lane_word(
    input logic [LVDS_DESER_FACTOR*LVDS_RX_LANES-1:0] word,
    input int                                         lane
  );
    return word[lane*LVDS_DESER_FACTOR +: LVDS_DESER_FACTOR];
  endfunction

endpackage

// File: rtl/lvds_rx_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module lvds_rx_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/lvds_rx_frame_aligner.sv
// Bit-slip word aligner for a 9-lane 6x LVDS receiver (8 data + frame lane).
// Define LVDS_RX_ALIGN_STATS_EN to build the locked-state frame error counter.
module lvds_rx_frame_aligner
  import lvds_rx_pkg::*;
#(
  parameter logic [5:0] FRAME_PATTERN = LVDS_FRAME_PATTERN_DEFAULT,
  parameter int         FCLK_LANE     = 8,
  parameter int         LOCK_COUNT    = 64,
  parameter int         ALIGN_PULSE   = 2,
  parameter int         SLIP_WAIT     = 4,
  parameter int         MAX_SLIPS     = 12,
  parameter int         UNLOCK_MISSES = 4
) (
  input  logic        rx_clk_i,
  input  logic        reset_i,
  input  logic        rx_locked_i,
  input  logic [53:0] rx_data_i,
  output logic        rx_data_align_o,
  output logic        aligned_o,
  output logic        align_error_o,
  output logic [3:0]  slip_count_o,
  output logic [47:0] data_out_o,
  output logic        data_valid_o,
  output logic [15:0] frame_err_count_o
);

  localparam int WORD_W  = LVDS_DESER_FACTOR * LVDS_RX_LANES;
  localparam int DATA_W  = WORD_W - LVDS_DESER_FACTOR;
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_MISSES + 1);
  localparam int TMR_MAX = (ALIGN_PULSE > SLIP_WAIT) ? ALIGN_PULSE : SLIP_WAIT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  logic [1:0]         lock_sync_q;
  logic               locked_s;
  logic [WORD_W-1:0]  data_in_q;
  logic [DATA_W-1:0]  data_strip;
  logic [DATA_W-1:0]  data_out_q;
  lvds_rx_state_e     state_q, state_d;
  logic [3:0]         slip_q, slip_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               align_q, aligned_q, err_q;
  logic               frame_match;
  logic [MATCH_W-1:0] match_cnt;
  logic [MISS_W-1:0]  miss_cnt;

  assign locked_s    = lock_sync_q[1];
  assign frame_match = (lane_word(data_in_q, FCLK_LANE) == FRAME_PATTERN);

  // Drop the frame lane and close the gap so data lanes keep their order.
  genvar gi;
  generate
    for (gi = 0; gi < LVDS_RX_LANES; gi++) begin : g_lane
      if (gi < FCLK_LANE) begin : g_below
        assign data_strip[gi*LVDS_DESER_FACTOR +: LVDS_DESER_FACTOR] =
          data_in_q[gi*LVDS_DESER_FACTOR +: LVDS_DESER_FACTOR];
      end else if (gi > FCLK_LANE) begin : g_above
        assign data_strip[(gi-1)*LVDS_DESER_FACTOR +: LVDS_DESER_FACTOR] =
          data_in_q[gi*LVDS_DESER_FACTOR +: LVDS_DESER_FACTOR];
      end
    end
  endgenerate

  lvds_rx_sat_counter #(.WIDTH(MATCH_W)) u_match_cnt (
    .clk_i   (rx_clk_i),
    .rst_i   (reset_i),
    .clr_i   ((state_q != S_CHECK) || !frame_match),
    .inc_i   ((state_q == S_CHECK) && frame_match),
    .count_o (match_cnt)
  );

  lvds_rx_sat_counter #(.WIDTH(MISS_W)) u_miss_cnt (
    .clk_i   (rx_clk_i),
    .rst_i   (reset_i),
    .clr_i   ((state_q != S_LOCKED) || frame_match),
    .inc_i   ((state_q == S_LOCKED) && !frame_match),
    .count_o (miss_cnt)
  );

`ifdef LVDS_RX_ALIGN_STATS_EN
  lvds_rx_sat_counter #(.WIDTH(16)) u_frame_err_cnt (
    .clk_i   (rx_clk_i),
    .rst_i   (reset_i),
    .clr_i   (state_d == S_IDLE),
    .inc_i   ((state_q == S_LOCKED) && !frame_match),
    .count_o (frame_err_count_o)
  );
`else
  assign frame_err_count_o = '0;
`endif

  always_comb begin
    state_d = state_q;
    if (!locked_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_CHECK;
        S_CHECK: begin
          if (frame_match) begin
            if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) state_d = S_LOCKED;
          end else if (slip_q == 4'(MAX_SLIPS)) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_SLIP;
          end
        end
        S_SLIP:   if (tmr_q == TMR_W'(ALIGN_PULSE - 1)) state_d = S_WAIT;
        S_WAIT:   if (tmr_q == TMR_W'(SLIP_WAIT - 1)) state_d = S_CHECK;
        S_LOCKED: begin
          if (!frame_match && (miss_cnt == MISS_W'(UNLOCK_MISSES - 1))) state_d = S_CHECK;
        end
        S_FAIL:   state_d = S_FAIL;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    slip_d = slip_q;
    if (state_d == S_IDLE) begin
      slip_d = '0;
    end else if ((state_d == S_SLIP) && (state_q != S_SLIP) && (slip_q != 4'hF)) begin
      slip_d = slip_q + 4'd1;
    end
  end

  // One timer serves both the slip pulse and the settle window.
  always_comb begin
    tmr_d = '0;
    if ((state_d == state_q) && ((state_q == S_SLIP) || (state_q == S_WAIT))) begin
      tmr_d = tmr_q + TMR_W'(1);
    end
  end

  // Status outputs follow the next state so they change with it, glitch-free.
  always_ff @(posedge rx_clk_i or posedge reset_i) begin
    if (reset_i) begin
      lock_sync_q <= '0;
      data_in_q   <= '0;
      data_out_q  <= '0;
      state_q     <= S_IDLE;
      slip_q      <= '0;
      tmr_q       <= '0;
      align_q     <= 1'b0;
      aligned_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], rx_locked_i};
      data_in_q   <= rx_data_i;
      data_out_q  <= data_strip;
      state_q     <= state_d;
      slip_q      <= slip_d;
      tmr_q       <= tmr_d;
      align_q     <= (state_d == S_SLIP);
      aligned_q   <= (state_d == S_LOCKED);
      err_q       <= (state_d == S_FAIL);
    end
  end

  assign rx_data_align_o = align_q;
  assign aligned_o       = aligned_q;
  assign data_valid_o    = aligned_q;
  assign align_error_o   = err_q;
  assign slip_count_o    = slip_q;
  assign data_out_o      = data_out_q;

endmodule

// File: tb/tb_lvds_rx_frame_aligner.sv
// Self-checking bench for lvds_rx_frame_aligner: a deserializer model that
// rotates the frame lane one bit per slip pulse, table rows and random runs.
module tb_lvds_rx_frame_aligner;

  localparam logic [5:0] PAT      = 6'b111000;
  localparam int         LOCK_CYC = 64 + 3;      // 64 matches + 2 sync + 1
  localparam int         SLIP_CYC = 2 + 4 + 1;   // pulse + settle + compare
  localparam int         FAIL_CYC = 4 + 12 * SLIP_CYC;
  localparam int         UNLOCK   = 4;
`ifdef LVDS_RX_ALIGN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_locked;
  logic [53:0] rx_data;
  logic        rx_data_align, aligned, align_error, data_valid;
  logic [3:0]  slip_count;
  logic [47:0] data_out;
  logic [15:0] frame_err_count;

  lvds_rx_frame_aligner dut (
    .rx_clk_i          (clk),
    .reset_i           (reset),
    .rx_locked_i       (rx_locked),
    .rx_data_i         (rx_data),
    .rx_data_align_o   (rx_data_align),
    .aligned_o         (aligned),
    .align_error_o     (align_error),
    .slip_count_o      (slip_count),
    .data_out_o        (data_out),
    .data_valid_o      (data_valid),
    .frame_err_count_o (frame_err_count)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          rot;
  logic [5:0]  base;
  bit          bad_next;
  logic [47:0] w_m1, w_m2, exp_dout;
  bit          align_prev;
  int          pulses;
  bit          hold_seq[$];

  typedef struct {
    int         rot;
    logic [5:0] base;
    int         slips;
    int         cycles;
    bit         fail;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [5:0] rotl(input logic [5:0] p, input int r);
    logic [5:0] t;
    t = p;
    for (int k = 0; k < r; k++) t = {t[4:0], t[5]};
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Frame lane 8 sits on top of the 8 random data lanes.
  task automatic drive_word();
    logic [47:0] d;
    logic [5:0]  f;
    d = 48'({$urandom(), $urandom()});
    f = bad_next ? 6'b000111 : rotl(base, rot);
    rx_data = {f, d};
    w_m1 = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    exp_dout = w_m2;
    if (rx_data_align && !align_prev) begin
      rot = (rot + 1) % 6;
      pulses++;
    end
    align_prev = rx_data_align;
    w_m2 = w_m1;
    drive_word();
  endtask

  task automatic do_reset();
    rx_locked = 1'b0;
    bad_next  = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    reset      = 1'b0;
    align_prev = 1'b0;
    pulses     = 0;
  endtask

  task automatic acquire(input int r, input logic [5:0] b, output int cyc);
    rot       = r;
    base      = b;
    pulses    = 0;
    rx_locked = 1'b1;
    drive_word();
    cyc = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (aligned || align_error) begin
        cyc = i;
        break;
      end
    end
    check("acquire_done", aligned | align_error, 1);
  endtask

  // Model: a frame driven at tick t is judged at tick t+2; lock drops on
  // the UNLOCK-th consecutive bad frame, and every bad frame before that counts.
  task automatic run_hold(output bit dropped, output int errs);
    bit hist[$];
    int n, run;
    bit d;
    n = hold_seq.size();
    dropped = 1'b0;
    errs = 0;
    for (int t = 0; t < n + 3 && !dropped; t++) begin
      bad_next = (t < n) ? hold_seq[t] : 1'b0;
      tick();
      hist.push_back(bad_next);
      run = 0; errs = 0; d = 1'b0;
      for (int k = 0; k <= t - 2; k++) begin
        if (!d) begin
          if (hist[k]) begin
            errs++; run++;
            if (run == UNLOCK) d = 1'b1;
          end else begin
            run = 0;
          end
        end
      end
      dropped = d;
      check("hold_aligned", aligned, !dropped);
      check("hold_valid", data_valid, !dropped);
    end
    check("hold_err_count", frame_err_count, STATS ? errs : 0);
    bad_next = 1'b0;
  endtask

  initial begin
    int  cyc, s, errs;
    bit  drop;

    reset = 1'b1; rx_locked = 1'b0; rx_data = '0;
    rot = 0; base = PAT; bad_next = 1'b0;
    w_m1 = '0; w_m2 = '0; exp_dout = '0; align_prev = 1'b0; pulses = 0;

    vecs[0] = '{0, PAT,         0,  LOCK_CYC,                0};
    vecs[1] = '{2, PAT,         4,  LOCK_CYC + 4 * SLIP_CYC, 0};
    vecs[2] = '{5, PAT,         1,  LOCK_CYC + 1 * SLIP_CYC, 0};
    vecs[3] = '{1, PAT,         5,  LOCK_CYC + 5 * SLIP_CYC, 0};
    vecs[4] = '{0, 6'b010101,  12,  FAIL_CYC,                1};

    do_reset();
    check("rst_align", rx_data_align, 0);
    check("rst_aligned", aligned, 0);
    check("rst_error", align_error, 0);
    check("rst_slips", slip_count, 0);
    check("rst_dout", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_errcnt", frame_err_count, 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      acquire(vecs[i].rot, vecs[i].base, cyc);
      check("vec_cycles", cyc, vecs[i].cycles);
      check("vec_aligned", aligned, !vecs[i].fail);
      check("vec_error", align_error, vecs[i].fail);
      check("vec_slips", slip_count, vecs[i].slips);
      check("vec_pulses", pulses, vecs[i].slips);
      if (!vecs[i].fail) begin
        for (int k = 0; k < 6; k++) begin
          tick();
          check("vec_dout", data_out, exp_dout);
          check("vec_valid", data_valid, 1);
        end
      end
    end

    // Leave FAIL through IDLE, then retry with a good frame lane.
    rx_locked = 1'b0;
    repeat (4) tick();
    check("retry_idle_error", align_error, 0);
    check("retry_idle_slips", slip_count, 0);
    acquire(0, PAT, cyc);
    check("retry_cycles", cyc, LOCK_CYC);
    check("retry_slips", slip_count, 0);

    hold_seq.delete();
    hold_seq = '{1, 1, 1, 0, 1, 1, 1, 1};
    run_hold(drop, errs);
    check("miss314_dropped", drop, 1);
    check("miss314_errcnt", frame_err_count, STATS ? 7 : 0);

    for (int it = 0; it < 6; it++) begin
      do_reset();
      s = $urandom_range(0, 5);
      acquire(s, PAT, cyc);
      s = (6 - s) % 6;
      check("rand_slips", slip_count, s);
      check("rand_cycles", cyc, LOCK_CYC + s * SLIP_CYC);
      hold_seq.delete();
      for (int k = 0; k < 20; k++) hold_seq.push_back($urandom_range(0, 2) == 0);
      run_hold(drop, errs);
    end

    // Pull rx_locked during a slip pulse.
    do_reset();
    rot = 2; base = PAT; rx_locked = 1'b1; drive_word();
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rx_data_align) break;
    end
    check("abort_pulse_seen", rx_data_align, 1);
    rx_locked = 1'b0;
    repeat (3) tick();
    check("abort_align_low", rx_data_align, 0);
    check("abort_slips", slip_count, 0);
    repeat (4) tick();
    check("abort_align_stays_low", rx_data_align, 0);

    // Asynchronous reset while locked clears outputs before the next edge.
    do_reset();
    acquire(0, PAT, cyc);
    repeat (3) tick();
    check("pre_reset_aligned", aligned, 1);
    #2 reset = 1'b1;
    #1;
    check("areset_aligned", aligned, 0);
    check("areset_valid", data_valid, 0);
    check("areset_dout", data_out, 0);
    check("areset_slips", slip_count, 0);
    check("areset_errcnt", frame_err_count, 0);
    tick();
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
